gtpu_n3_header_inserter: RTL and testbench
==========================================

// Module: gtpu_n3_header_inserter
// PURPOSE
//  N3-direction header creator, parametrised successor of the fixed-layout N3 creator.
//  Prepends a 16-byte GTP-U header with a PDU Session Container to each N6-side packet.
//  Fields come from a per-packet ADS_N6-style metadata word (int_gate/TEID/QFI/DSCP/Q_ID).
//  Sits between the N6 classifier and the N3 egress arbiter.
//  Adds a closed-gate drop path, length-overflow drop, and drop/forward counters.
// PARAMETERS
//  DATA_W  128  stream width in bits; legal values 64 or 128 only (header = 16/DATA_W*8 beats)
//  CNT_W   32   width of statistics counters; counters saturate at all-ones
//  TUSER_W 24   egress sideband width = {DSCP[7:0], Q_ID[15:0]}
// PORTS
//  clk           in   1          single clock, all logic rising edge
//  rst_n         in   1          synchronous reset, active-low
//  meta_valid    in   1          metadata word valid
//  meta_ready    out  1          metadata accepted when valid&ready
//  meta_gate     in   8          int_gate; bit0=1 forward, bit0=0 drop packet
//  meta_teid     in   32         GTPU_TEID
//  meta_qfi      in   8          QFI; only [5:0] used, [7:6] ignored
//  meta_dscp     in   8          DSCP, forwarded on m_tuser
//  meta_qid      in   16         Q_ID, forwarded on m_tuser
//  meta_len      in   16         inner packet length in bytes
//  s_tdata/s_tkeep/s_tlast/s_tvalid/s_tready  in/in/in/in/out  DATA_W/DATA_W/8/1/1/1  payload stream in
//  m_tdata/m_tkeep/m_tlast/m_tvalid/m_tready  out/out/out/out/in  DATA_W/DATA_W/8/1/1/1  stream out
//  m_tuser       out  TUSER_W    {dscp,qid}, constant for all beats of a packet
//  fwd_cnt       out  CNT_W      packets forwarded (counted at tlast handshake)
//  drop_cnt      out  CNT_W      packets dropped (gate closed or length overflow)
// BEHAVIOUR
//  Reset: all state cleared. IDLE; meta_ready=1, s_tready=0, m_tvalid=0, m_tdata/m_tkeep/m_tuser=0, m_tlast=0, counters=0.
//  FSM: IDLE -> HDR (gate open, len<=0xFFF7) | DROP (otherwise) on meta handshake. HDR -> PAY after last header beat accepted.
//       PAY -> IDLE on s_tlast handshake. DROP -> IDLE on s_tlast handshake.
//  Metadata is latched on handshake. meta_ready=1 only in IDLE; one packet in flight.
//  Header, byte0 = m_tdata MSB byte, big-endian:
//   B0=0x34 B1=0xFF B2-3=meta_len+8 B4-7=TEID B8-9=0x0000 B10=0x00 B11=0x85
//   B12=0x01 B13=0x00 B14={2'b00,QFI[5:0]} B15=0x00
//  Header beats carry m_tkeep all-ones and m_tlast=0.
//  First header beat: m_tvalid rises cycle after meta handshake (latency 1).
//  Output register: a beat holds m_tdata/m_tkeep/m_tlast/m_tuser stable while m_tvalid&!m_tready.
//  PAY: s_tready = m_tready | !m_tvalid. Beats are copied unchanged (data, keep, last) with 1-cycle latency.
//   Full throughput: one beat/cycle when m_tready stays high.
//  DROP: s_tready=1 and m_tvalid=0; beats are consumed and discarded.
//  s_tready=0 in IDLE/HDR; payload is never accepted before its metadata.
//  Counters: fwd_cnt+1 at m_tlast handshake. drop_cnt+1 on entering DROP. Both saturate, never wrap.
//  Simultaneous events: meta handshake same cycle as final m_tlast handshake is legal only if the FSM is already IDLE.
//   No overlap; meta_ready stays 0 until the FSM returns to IDLE.
//  meta_len=0xFFF7 -> length field 0xFFFF and packet forwarded. 0xFFF8..0xFFFF -> drop.
//  rst_n low mid-packet: same-cycle-registered abort to reset state.
//   The partial packet is not completed; upstream must also be reset.
// TESTING
//  T1 DATA_W=128, meta{gate=1,teid=0xDEADBEEF,qfi=0x09,dscp=0x2E,qid=0x0003,len=64}, 4 payload beats.
//     -> beat0 = 0x34FF0048_DEADBEEF_00000085_01000900, then 4 payload beats unchanged.
//     -> m_tuser=0x2E0003 on every beat, fwd_cnt=1.
//  T2 gate=0x00, 3-beat packet -> s_tready=1 for 3 beats, no m_tvalid, drop_cnt=1, meta_ready back after tlast.
//  T3 len=0xFFF7 -> B2-3=0xFFFF, forwarded. len=0xFFF8 -> dropped, drop_cnt+1.
//  T4 m_tready random 50% during T1 traffic -> byte-identical output vs m_tready=1.
//     -> m_* stable while stalled, no beat lost or duplicated.
//  T5 DATA_W=64 -> two header beats 0x34FF0048DEADBEEF, 0x0000008501000900; qfi=0xFF -> B14=0x3F.
//  T6 rst_n low for 1 cycle during payload beat 2 -> all outputs at reset values next cycle; next packet correct.

Source files
------------

// File: rtl/gtpu_n3_header_inserter_if.sv
// ---------------------------------------------------------------------------
// gtpu_n3_header_inserter_if
// Purpose : bundles the metadata handshake, the N6-side payload stream and the
//           N3-side output stream of the GTP-U N3 header inserter.
// Signals : meta_*  per-packet metadata word (valid/ready handshake)
//           s_t*    payload stream into the inserter
//           m_t*    header + payload stream out of the inserter, m_tuser sideband
// Modports: slave  - the inserter's view
//           master - the view of the surrounding logic (classifier/arbiter/bench)
// ---------------------------------------------------------------------------
interface gtpu_n3_header_inserter_if #(
    parameter int DATA_W  = 128,
    parameter int TUSER_W = 24
);
    logic                  meta_valid;
    logic                  meta_ready;
    logic [7:0]            meta_gate;
    logic [31:0]           meta_teid;
    logic [7:0]            meta_qfi;
    logic [7:0]            meta_dscp;
    logic [15:0]           meta_qid;
    logic [15:0]           meta_len;

    logic [DATA_W-1:0]     s_tdata;
    logic [DATA_W/8-1:0]   s_tkeep;
    logic                  s_tlast;
    logic                  s_tvalid;
    logic                  s_tready;

    logic [DATA_W-1:0]     m_tdata;
    logic [DATA_W/8-1:0]   m_tkeep;
    logic                  m_tlast;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [TUSER_W-1:0]    m_tuser;

    modport slave (
        input  meta_valid, meta_gate, meta_teid, meta_qfi, meta_dscp, meta_qid, meta_len,
        output meta_ready,
        input  s_tdata, s_tkeep, s_tlast, s_tvalid,
        output s_tready,
        output m_tdata, m_tkeep, m_tlast, m_tvalid, m_tuser,
        input  m_tready
    );

    modport master (
        output meta_valid, meta_gate, meta_teid, meta_qfi, meta_dscp, meta_qid, meta_len,
        input  meta_ready,
        output s_tdata, s_tkeep, s_tlast, s_tvalid,
        input  s_tready,
        input  m_tdata, m_tkeep, m_tlast, m_tvalid, m_tuser,
        output m_tready
    );
endinterface

// File: rtl/gtpu_n3_header_inserter.sv
// ---------------------------------------------------------------------------
// gtpu_n3_header_inserter
// Purpose : prepends a 16-byte GTP-U header (with PDU Session Container) to
//           each N6-side packet, driven by one metadata word per packet.
//           Packets with a closed gate or an inner length that would overflow
//           the 16-bit GTP-U length field are consumed and discarded.
// Ports   : clk       single rising-edge clock
//           rst_n     synchronous active-low reset
//           bus       metadata / payload-in / stream-out bundle (slave view)
//           fwd_cnt   saturating count of packets forwarded (at m_tlast handshake)
//           drop_cnt  saturating count of packets dropped
// DATA_W must be 64 or 128; the header then takes 2 or 1 output beats.
// ---------------------------------------------------------------------------
module gtpu_n3_header_inserter #(
    parameter int DATA_W  = 128,
    parameter int CNT_W   = 32,
    parameter int TUSER_W = 24
) (
    input  logic                      clk,
    input  logic                      rst_n,
    gtpu_n3_header_inserter_if.slave  bus,
    output logic [CNT_W-1:0]          fwd_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);
    localparam int         KEEP_W    = DATA_W / 8;
    localparam int         HDR_BEATS = 128 / DATA_W;
    localparam logic [1:0] HDR_LAST  = 2'(HDR_BEATS);
    localparam logic [15:0] MAX_LEN  = 16'hFFF7;   // largest len whose len+8 fits in 16 bits

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DROP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_len;
    logic [31:0]         r_teid;
    logic [5:0]          r_qfi;
    logic [1:0]          r_hdr_idx;      // number of header beats already loaded
    logic [DATA_W-1:0]   r_m_tdata;
    logic [KEEP_W-1:0]   r_m_tkeep;
    logic                r_m_tlast;
    logic                r_m_tvalid;
    logic [TUSER_W-1:0]  r_m_tuser;
    logic [CNT_W-1:0]    r_fwd_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;

    logic                w_meta_ready;
    logic                w_s_tready;
    logic                w_meta_fire;
    logic                w_s_fire;
    logic                w_m_fire;
    logic                w_out_free;
    logic                w_open;
    logic [127:0]        w_hdr_in;
    logic [127:0]        w_hdr_reg;
    logic                w_unused;

    // Full 16-byte header, byte 0 in the MSBs.
    function automatic logic [127:0] make_hdr(input logic [15:0] len,
                                              input logic [31:0] teid,
                                              input logic [5:0]  qfi);
        make_hdr = {8'h34, 8'hFF, len + 16'd8, teid, 16'h0000, 8'h00, 8'h85,
                    8'h01, 8'h00, 2'b00, qfi, 8'h00};
    endfunction

    function automatic logic [DATA_W-1:0] hdr_beat(input logic [127:0] hdr,
                                                   input logic [1:0]   idx);
        hdr_beat = hdr[127 - int'(idx) * DATA_W -: DATA_W];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w_out_free  = !r_m_tvalid || bus.m_tready;
    assign w_meta_fire = bus.meta_valid && w_meta_ready;
    assign w_s_fire    = bus.s_tvalid && w_s_tready;
    assign w_m_fire    = r_m_tvalid && bus.m_tready;
    assign w_open      = bus.meta_gate[0] && (bus.meta_len <= MAX_LEN);
    // First beat is built straight from the metadata inputs so it can be
    // registered on the handshake edge; later beats use the latched copy.
    assign w_hdr_in    = make_hdr(bus.meta_len, bus.meta_teid, bus.meta_qfi[5:0]);
    assign w_hdr_reg   = make_hdr(r_len, r_teid, r_qfi);
    assign w_unused    = &{1'b0, bus.meta_gate[7:1], bus.meta_qfi[7:6]};

    always_comb begin
        w_state_nxt  = r_state;
        w_meta_ready = 1'b0;
        w_s_tready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Wait until a trailing tlast beat has drained (or drains
                // this cycle) so the header never overwrites it.
                w_meta_ready = w_out_free;
                if (bus.meta_valid && w_out_free)
                    w_state_nxt = w_open ? S_HDR : S_DROP;
            end
            S_HDR: begin
                if (w_m_fire && (r_hdr_idx == HDR_LAST))
                    w_state_nxt = S_PAY;
            end
            S_PAY: begin
                w_s_tready = w_out_free;
                if (bus.s_tvalid && w_out_free && bus.s_tlast)
                    w_state_nxt = S_IDLE;
            end
            S_DROP: begin
                w_s_tready = 1'b1;
                if (bus.s_tvalid && bus.s_tlast)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_teid     <= '0;
            r_qfi      <= '0;
            r_hdr_idx  <= '0;
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tlast  <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_m_tuser  <= '0;
            r_fwd_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            // An accepted beat empties the output register unless a new
            // beat is loaded below in the same cycle.
            if (w_m_fire)
                r_m_tvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_meta_fire) begin
                        r_len  <= bus.meta_len;
                        r_teid <= bus.meta_teid;
                        r_qfi  <= bus.meta_qfi[5:0];
                        if (w_open) begin
                            r_m_tdata  <= hdr_beat(w_hdr_in, 2'd0);
                            r_m_tkeep  <= '1;
                            r_m_tlast  <= 1'b0;
                            r_m_tvalid <= 1'b1;
                            r_m_tuser  <= {bus.meta_dscp, bus.meta_qid};
                            r_hdr_idx  <= 2'd1;
                        end
                    end
                end
                S_HDR: begin
                    if (w_m_fire && (r_hdr_idx != HDR_LAST)) begin
                        r_m_tdata  <= hdr_beat(w_hdr_reg, r_hdr_idx);
                        r_m_tkeep  <= '1;
                        r_m_tlast  <= 1'b0;
                        r_m_tvalid <= 1'b1;
                        r_hdr_idx  <= r_hdr_idx + 2'd1;
                    end
                end
                S_PAY: begin
                    if (w_s_fire) begin
                        r_m_tdata  <= bus.s_tdata;
                        r_m_tkeep  <= bus.s_tkeep;
                        r_m_tlast  <= bus.s_tlast;
                        r_m_tvalid <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (w_m_fire && r_m_tlast)
                r_fwd_cnt <= sat_inc(r_fwd_cnt);
            if (w_meta_fire && !w_open)
                r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    assign bus.meta_ready = w_meta_ready;
    assign bus.s_tready   = w_s_tready;
    assign bus.m_tdata    = r_m_tdata;
    assign bus.m_tkeep    = r_m_tkeep;
    assign bus.m_tlast    = r_m_tlast;
    assign bus.m_tvalid   = r_m_tvalid;
    assign bus.m_tuser    = r_m_tuser;
    assign fwd_cnt        = r_fwd_cnt;
    assign drop_cnt       = r_drop_cnt;
endmodule

// File: tb/tb_gtpu_n3_header_inserter.sv
// ---------------------------------------------------------------------------
// tb_gtpu_n3_header_inserter
// Directed bench for the GTP-U N3 header inserter: a 128-bit instance carries
// the main traffic, a 64-bit instance checks the two-beat header layout.
// ---------------------------------------------------------------------------
module tb_gtpu_n3_header_inserter;
    typedef logic [168:0] beat_t;   // {tuser[23:0], tlast, tkeep[15:0], tdata[127:0]}

    localparam logic [127:0] HDR_T1   = 128'h34FF0048_DEADBEEF_00000085_01000900;
    localparam logic [127:0] HDR_FFF7 = 128'h34FFFFFF_DEADBEEF_00000085_01000900;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] fwd_cnt, drop_cnt, fwd64, drop64;

    int    n_assert = 0;
    int    n_fail   = 0;
    int    stalls   = 0;
    bit    rnd_mode = 1'b0;
    bit    seen_valid = 1'b0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t q[$];
    beat_t ref_q[$];

    always #5 clk = ~clk;

    gtpu_n3_header_inserter_if #(.DATA_W(128), .TUSER_W(24)) bif();
    gtpu_n3_header_inserter_if #(.DATA_W(64),  .TUSER_W(24)) bif64();

    gtpu_n3_header_inserter #(.DATA_W(128), .CNT_W(32), .TUSER_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt));

    gtpu_n3_header_inserter #(.DATA_W(64), .CNT_W(32), .TUSER_W(24)) dut64 (
        .clk(clk), .rst_n(rst_n), .bus(bif64), .fwd_cnt(fwd64), .drop_cnt(drop64));

    task automatic chk(input string tag, input logic [168:0] obs, input logic [168:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        return {bif.m_tuser, bif.m_tlast, bif.m_tkeep, bif.m_tdata};
    endfunction

    function automatic logic [127:0] pay(input int i);
        return {4{32'(32'hC0DE0000 + i)}};
    endfunction

    function automatic beat_t mk(input logic [127:0] d, input logic [15:0] k, input logic l);
        return {24'h2E0003, l, k, d};
    endfunction

    // Downstream ready: constant 1 or a 50% random pattern, changed at negedge.
    always @(negedge clk)
        bif.m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;

    // Output monitor: records accepted beats and checks that a stalled beat holds.
    always begin
        @(negedge clk);
        #2;
        if (prev_stall) begin
            chk("stall_hold_valid", bif.m_tvalid, 1'b1);
            chk("stall_hold_beat", cur_beat(), prev_beat);
        end
        if (bif.m_tvalid === 1'b1) seen_valid = 1'b1;
        if (bif.m_tvalid === 1'b1 && bif.m_tready === 1'b1) q.push_back(cur_beat());
        prev_stall = (bif.m_tvalid === 1'b1) && (bif.m_tready === 1'b0) && rst_n;
        prev_beat  = cur_beat();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_meta(input logic [7:0] gate, input logic [7:0] qfi, input logic [15:0] len);
        bif.meta_gate  = gate;
        bif.meta_qfi   = qfi;
        bif.meta_len   = len;
        bif.meta_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (bif.meta_ready) break;
        end
        chk("meta_ready_wait", bif.meta_ready, 1'b1);
        tick();
        bif.meta_valid = 1'b0;
    endtask

    task automatic push_beat(input logic [127:0] d, input logic [15:0] k, input logic l);
        bif.s_tdata  = d;
        bif.s_tkeep  = k;
        bif.s_tlast  = l;
        bif.s_tvalid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #1;
            if (bif.s_tready) break;
            stalls++;
        end
        chk("s_ready_wait", bif.s_tready, 1'b1);
        tick();
    endtask

    task automatic run_pkt(input logic [7:0] gate, input logic [15:0] len, input int nb);
        send_meta(gate, 8'h09, len);
        chk("meta_latency_valid", bif.m_tvalid, gate[0] && (len <= 16'hFFF7));
        for (int i = 0; i < nb; i++)
            push_beat(pay(i), (i == nb - 1) ? 16'hFFF0 : 16'hFFFF, i == nb - 1);
        bif.s_tvalid = 1'b0;
        bif.s_tlast  = 1'b0;
    endtask

    task automatic wait_q(input int n, input int budget);
        for (int k = 0; k < budget && q.size() < n; k++) tick();
        chk("out_beat_count", q.size(), n);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_h1;
        logic [63:0] d64;
        bif.meta_valid = 1'b0;  bif.meta_gate = 8'h01;  bif.meta_teid = 32'hDEADBEEF;
        bif.meta_qfi   = 8'h09; bif.meta_dscp = 8'h2E;  bif.meta_qid  = 16'h0003;
        bif.meta_len   = 16'd64;
        bif.s_tdata = '0; bif.s_tkeep = '0; bif.s_tlast = 1'b0; bif.s_tvalid = 1'b0;
        bif64.meta_valid = 1'b0;  bif64.meta_gate = 8'h01;  bif64.meta_teid = 32'hDEADBEEF;
        bif64.meta_qfi   = 8'h09; bif64.meta_dscp = 8'h2E;  bif64.meta_qid  = 16'h0003;
        bif64.meta_len   = 16'd64;
        bif64.s_tdata = '0; bif64.s_tkeep = '0; bif64.s_tlast = 1'b0; bif64.s_tvalid = 1'b0;
        bif64.m_tready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_meta_ready", bif.meta_ready, 1'b1);
        chk("rst_s_tready",   bif.s_tready,   1'b0);
        chk("rst_m_tvalid",   bif.m_tvalid,   1'b0);
        chk("rst_m_tdata",    bif.m_tdata,    '0);
        chk("rst_m_tkeep",    bif.m_tkeep,    '0);
        chk("rst_m_tlast",    bif.m_tlast,    1'b0);
        chk("rst_m_tuser",    bif.m_tuser,    '0);
        chk("rst_fwd_cnt",    fwd_cnt,        '0);
        chk("rst_drop_cnt",   drop_cnt,       '0);
        chk("rst64_m_tvalid", bif64.m_tvalid, 1'b0);
        rst_n = 1'b1;
        tick();

        // T1: basic forward, 4 payload beats
        q.delete();
        run_pkt(8'h01, 16'd64, 4);
        wait_q(5, 100);
        tick();
        chk("t1_hdr", q[0], mk(HDR_T1, 16'hFFFF, 1'b0));
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_pay%0d", i), q[i+1], mk(pay(i), (i == 3) ? 16'hFFF0 : 16'hFFFF, i == 3));
        chk("t1_fwd_cnt", fwd_cnt, 32'd1);
        chk("t1_meta_ready", bif.meta_ready, 1'b1);
        ref_q = q;

        // T2: closed gate -> consumed, nothing out
        q.delete(); seen_valid = 1'b0; stalls = 0;
        run_pkt(8'h00, 16'd64, 3);
        tick();
        chk("t2_no_stall", stalls, 0);
        chk("t2_no_valid", seen_valid, 1'b0);
        chk("t2_drop_cnt", drop_cnt, 32'd1);
        chk("t2_meta_ready", bif.meta_ready, 1'b1);
        chk("t2_fwd_cnt", fwd_cnt, 32'd1);

        // T3: length boundary
        q.delete();
        run_pkt(8'h01, 16'hFFF7, 1);
        wait_q(2, 100);
        tick();
        chk("t3_hdr_fff7", q[0], mk(HDR_FFF7, 16'hFFFF, 1'b0));
        chk("t3_pay_fff7", q[1], mk(pay(0), 16'hFFF0, 1'b1));
        chk("t3_fwd_cnt", fwd_cnt, 32'd2);
        q.delete(); seen_valid = 1'b0;
        run_pkt(8'h01, 16'hFFF8, 2);
        tick();
        chk("t3_drop_fff8", drop_cnt, 32'd2);
        chk("t3_no_valid_fff8", seen_valid, 1'b0);
        chk("t3_meta_ready", bif.meta_ready, 1'b1);

        // T4: random backpressure, output must match T1
        rnd_mode = 1'b1;
        q.delete();
        run_pkt(8'h01, 16'd64, 4);
        wait_q(5, 400);
        tick();
        rnd_mode = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 5; i++)
            chk($sformatf("t4_beat%0d", i), q[i], ref_q[i]);
        chk("t4_fwd_cnt", fwd_cnt, 32'd3);

        // T5: 64-bit instance, two header beats, QFI upper bits ignored
        for (int p = 0; p < 2; p++) begin
            bif64.meta_qfi = (p == 0) ? 8'h09 : 8'hFF;
            exp_h1 = (p == 0) ? 64'h00000085_01000900 : 64'h00000085_01003F00;
            d64 = 64'h11223344_55667788 + 64'(p);
            bif64.meta_valid = 1'b1;
            chk("t5_meta_ready", bif64.meta_ready, 1'b1);
            tick();
            bif64.meta_valid = 1'b0;
            chk("t5_hdr0", {bif64.m_tvalid, bif64.m_tlast, bif64.m_tkeep, bif64.m_tdata},
                {1'b1, 1'b0, 8'hFF, 64'h34FF0048_DEADBEEF});
            tick();
            chk("t5_hdr1", {bif64.m_tvalid, bif64.m_tlast, bif64.m_tkeep, bif64.m_tdata},
                {1'b1, 1'b0, 8'hFF, exp_h1});
            tick();
            bif64.s_tdata = d64; bif64.s_tkeep = 8'h0F; bif64.s_tlast = 1'b1; bif64.s_tvalid = 1'b1;
            chk("t5_s_tready", bif64.s_tready, 1'b1);
            tick();
            bif64.s_tvalid = 1'b0;
            chk("t5_pay", {bif64.m_tvalid, bif64.m_tlast, bif64.m_tkeep, bif64.m_tdata},
                {1'b1, 1'b1, 8'h0F, d64});
            chk("t5_tuser", bif64.m_tuser, 24'h2E0003);
            tick();
        end
        chk("t5_fwd_cnt", fwd64, 32'd2);

        // T6: reset during payload beat 2, then a clean packet
        tick();
        send_meta(8'h01, 8'h09, 16'd64);
        push_beat(pay(0), 16'hFFFF, 1'b0);
        push_beat(pay(1), 16'hFFFF, 1'b0);
        bif.s_tdata = pay(2); bif.s_tkeep = 16'hFFFF; bif.s_tlast = 1'b0; bif.s_tvalid = 1'b1;
        rst_n = 1'b0;
        tick();
        chk("t6_m_tvalid",   bif.m_tvalid,   1'b0);
        chk("t6_m_tdata",    bif.m_tdata,    '0);
        chk("t6_m_tkeep",    bif.m_tkeep,    '0);
        chk("t6_m_tlast",    bif.m_tlast,    1'b0);
        chk("t6_m_tuser",    bif.m_tuser,    '0);
        chk("t6_meta_ready", bif.meta_ready, 1'b1);
        chk("t6_s_tready",   bif.s_tready,   1'b0);
        chk("t6_fwd_cnt",    fwd_cnt,        '0);
        chk("t6_drop_cnt",   drop_cnt,       '0);
        rst_n = 1'b1;
        bif.s_tvalid = 1'b0;
        tick();
        q.delete();
        run_pkt(8'h01, 16'd64, 4);
        wait_q(5, 100);
        tick();
        for (int i = 0; i < 5; i++)
            chk($sformatf("t6_beat%0d", i), q[i], ref_q[i]);
        chk("t6_fwd_cnt_after", fwd_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
